bus_arbiter4: RTL
=================

BUS_ARBITER4 -- requirements
Module: bus_arbiter4

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, is the number of cycles a grant may stay active without done before it is aborted; the legal range is 1..255.
REQ-002 Port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port req, input, 4 bits: request from each requester; bit i belongs to requester i.
REQ-005 Port done, input, 1 bit: the shared slave signals completion of the current transfer.
REQ-006 Port grant, output, 4 bits: one-hot grant to the current owner, or all zero.
REQ-007 Port sel, output, 2 bits: encoded owner index; drives the select of the shared 4:1 32-bit datapath mux.
REQ-008 Port busy, output, 1 bit: high while a grant is active.
REQ-009 Port timeout_err, output, 1 bit: a one-cycle pulse when a grant is aborted by timeout.

Function
REQ-010 The block SHALL implement two states: IDLE and OWNED.
REQ-011 All outputs SHALL be registered, with no combinational path from req or done to any output.
REQ-012 In IDLE with req != 0, the next edge SHALL enter OWNED, set grant to the winner, set sel to the winner's index, set busy to 1 and clear the timeout counter.
REQ-013 Arbitration SHALL be round-robin: with last = index of the previous owner, priority order is (last+1), (last+2), (last+3), last, all mod 4.
REQ-014 In IDLE with req == 0, grant, busy and the counter SHALL remain 0, and sel SHALL hold its previous value.
REQ-015 In OWNED, grant and sel SHALL stay constant regardless of changes on other req bits.
REQ-016 In OWNED, an edge with done=1 SHALL return to IDLE, clear grant and busy, and load last with the owner index.
REQ-017 In OWNED, an edge with the owner's req bit at 0 and done=0 SHALL release exactly as for done; this is an early withdrawal and SHALL NOT set timeout_err.
REQ-018 In OWNED, the 8-bit counter SHALL increment each edge with done=0 and the owner's req still high.
REQ-019 When the counter equals TIMEOUT_CYCLES-1 and done=0, the next edge SHALL release as in REQ-016 and pulse timeout_err for exactly one cycle.
REQ-020 done=1 on the same edge as the timeout condition SHALL count as a normal completion, with no timeout_err.
REQ-021 After every release the block SHALL spend at least one IDLE cycle; re-arbitration happens at the following edge, so at most one grant is issued per two cycles.
REQ-022 done received while in IDLE SHALL be ignored.
REQ-023 grant SHALL never have more than one bit set, and grant[sel] SHALL equal busy at all times.

Reset
REQ-024 While rst=1, the block SHALL force state=IDLE, grant=4'b0000, sel=2'b00, busy=0, timeout_err=0, counter=0 and last=3, with no clock required.
REQ-025 Reset asserted during OWNED SHALL abort the grant immediately without a timeout_err pulse.
REQ-026 The first arbitration after reset SHALL favour requester 0.
REQ-027 The first edge after rst deasserts SHALL evaluate req normally.

Verification
REQ-028 Reset priority: after reset, req=4'b1111 at cycle 0 -> at cycle 1 grant=0001, sel=00, busy=1; done=1 at cycle 2 -> at cycle 3 grant=0000; at cycle 4 grant=0010, sel=01.
REQ-029 Rotation: req=4'b1111 held and done pulsed on each owned cycle -> sel sequence 0,1,2,3,0 with one IDLE cycle between grants.
REQ-030 Timeout: TIMEOUT_CYCLES=4, req=0100, done held at 0 -> grant=0100 for exactly 4 cycles, then timeout_err=1 for one cycle, grant=0000 and last=2.
REQ-031 Withdrawal: grant=1000, then req[3] falls with done=0 -> the next edge gives grant=0000, busy=0, timeout_err=0; with req=0011 pending, the following edge gives grant=0001.
REQ-032 Mid-operation reset: grant=0100 active, then rst pulsed asynchronously between edges -> outputs go to 0 and sel to 00 immediately; after release, req=0100 gives grant=0100 one edge later.
REQ-033 Collision: done=1 on the same edge the timeout would fire -> release with timeout_err=0.

Source files
------------

// File: rtl/bus_arbiter4.sv
// bus_arbiter4: four-requester round-robin arbiter for one shared slave.
// A grant is held until the slave signals done, the owner withdraws its
// request, or the grant has been active for TIMEOUT_CYCLES cycles.
// Every output is a flop, so nothing on req or done reaches an output
// without first passing through a register.
//
// Handshake: req[i] is a level request that requester i holds high until
// it is granted. Once granted, the requester keeps req[i] high for as long
// as it wants the bus. The grant ends on the first edge where done=1
// (completion), req[owner]=0 (withdrawal) or the timeout fires. done is
// meaningful only while busy=1; in IDLE it is ignored.
module bus_arbiter4 #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       busy,
  output logic       timeout_err
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  // Counter value at which an edge with done=0 aborts the grant.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [1:0] last, last_n;
  logic [3:0] grant_n;
  logic [1:0] sel_n;
  logic       busy_n;
  logic       timeout_err_n;

  // The owner index that wins the next arbitration: search starts one
  // position after the previous owner and wraps, so the previous owner
  // comes last.
  function automatic logic [1:0] rr_pick(input logic [1:0] last_idx,
                                         input logic [3:0] r);
    logic [1:0] pick;
    logic [1:0] idx;
    logic       found;
    pick  = last_idx;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_idx + 2'(k);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  logic [1:0] winner;
  assign winner = rr_pick(last, req);

  // State and output registers; reset leaves last=3 so requester 0 is
  // favoured by the first arbitration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      last        <= 2'd3;
      grant       <= 4'b0000;
      sel         <= 2'b00;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      last        <= last_n;
      grant       <= grant_n;
      sel         <= sel_n;
      busy        <= busy_n;
      timeout_err <= timeout_err_n;
    end
  end

  // Next-state and next-output logic. A release always lands in IDLE, so
  // at least one idle cycle separates consecutive grants.
  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    last_n        = last;
    grant_n       = grant;
    sel_n         = sel;
    busy_n        = busy;
    timeout_err_n = 1'b0;

    unique case (state)
      IDLE: begin
        grant_n = 4'b0000;
        busy_n  = 1'b0;
        cnt_n   = 8'd0;
        if (req != 4'b0000) begin
          state_n = OWNED;
          grant_n = 4'b0001 << winner;
          sel_n   = winner;
          busy_n  = 1'b1;
        end
      end

      OWNED: begin
        if (done || !req[sel] || cnt == CNT_LAST) begin
          // Completion and withdrawal take precedence over the timeout;
          // only a grant still wanted and not completed is aborted.
          state_n       = IDLE;
          grant_n       = 4'b0000;
          busy_n        = 1'b0;
          cnt_n         = 8'd0;
          last_n        = sel;
          timeout_err_n = !done && req[sel];
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end

      default: begin
        state_n = IDLE;
        grant_n = 4'b0000;
        busy_n  = 1'b0;
        cnt_n   = 8'd0;
      end
    endcase
  end

endmodule
